instr_exec_reader: RTL and testbench
====================================

# instr_exec_reader

Read-side sequencer for the instruction register. It drives `read_pointer`, captures `instruction_word`, and executes the stored operation in a local ALU. It delivers one signed result per entry over a valid/ready handshake. It sits on the instruction register's read port, opposite the stimulus side that drives `load_en`/`write_pointer`, and replaces testbench-side result checking with a hardware consumer.

## Interface
Parameters:
- `NUM_ENTRIES`, 32: register depth; must equal 2**`ADDR_W`.
- `ADDR_W`, 5: pointer width (matches `address_t`).

Ports (reset is synchronous, active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `start`  in  1  begins a run; sampled only in IDLE.
- `first_ptr`  in  ADDR_W  first entry of the run.
- `count`  in  ADDR_W+1  entries to process, 0..NUM_ENTRIES.
- `read_pointer`  out  ADDR_W  address to the instruction register (registered).
- `instruction_word`  in  `instruction_t`  {opc[3:0], op_a[31:0] signed, op_b[31:0] signed}.
- `res_valid`  out  1  result bus holds a result.
- `res_ready`  in  1  consumer accepts the result.
- `result`  out  64  signed result.
- `res_ptr`  out  ADDR_W  entry the result came from.
- `res_opc`  out  4  opcode executed.
- `div_by_zero`  out  1  DIV/MOD with op_b==0.
- `illegal_op`  out  1  undefined or disabled opcode.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse; run complete.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, EXEC, OUT.
- IDLE:
  - `start`=1 and `count`>0: load `read_pointer`=`first_ptr`, remaining=`count`, go to FETCH.
  - `start`=1 and `count`==0: pulse `done` next cycle, stay IDLE.
- FETCH: one settle cycle for the register read, then go to CAPTURE.
- CAPTURE: latch `instruction_word`, go to EXEC.
- EXEC:
  - ALU result and flags are registered into the output bus, with `res_ptr`=`read_pointer`.
  - `res_valid`=1, go to OUT.
- OUT: holds every output stable until `res_valid`&&`res_ready`. On acceptance:
  - `res_valid`=0, remaining decrements.
  - remaining was >1: `read_pointer`+1, wrapping NUM_ENTRIES-1 -> 0; go to FETCH.
  - Otherwise: go to IDLE with `done`=1 for that cycle.
- `start` while busy is ignored. `first_ptr`/`count` are sampled only when a run begins.
- ALU (operands signed 32-bit, result signed 64-bit):
  - ZERO -> 0.
  - PASSA / PASSB -> sign-extended operand.
  - ADD / SUB -> sign-extended before the operation, so no overflow.
  - MULT -> full 64-bit product.
  - DIV -> truncates toward zero.
  - MOD -> sign follows the dividend.
  - DIV/MOD with op_b==0 -> result 0, `div_by_zero`=1.
  - Encodings 8..15 -> result 0, `illegal_op`=1.
  - Flags are per-result and valid with `res_valid`.
- Reset values: `read_pointer`=0, `res_valid`=0, `result`=0, `res_ptr`=0, `res_opc`=0, `div_by_zero`=0, `illegal_op`=0, `busy`=0, `done`=0; FSM in IDLE.

## Timing
- `start` is sampled at edge N. `read_pointer` is valid after N; the word is captured at N+2; `res_valid` rises after N+3.
- With `res_ready` held high, throughput is one result every 4 cycles. A run of k entries has `done` high in cycle N+4k.
- `instruction_word` must be stable within one cycle of a `read_pointer` change. This covers a combinational or single-registered read.
- `reset` at any edge aborts the run. Outputs take reset values on the next cycle; no `done` and no partial result.
- `res_ready` may be asserted before `res_valid`; it has no effect outside OUT.

## Configuration
- `INSTR_EXEC_DIV_EN` defined: DIV/MOD are implemented as above.
- Not defined: no divider is built. DIV/MOD return 0 with `illegal_op`=1 and `div_by_zero`=0.

## Structure
- `instr_register_pkg` holds `operand_t`, `opcode_t`, `address_t` and `instruction_t`. It also gains `result_t` (signed 64-bit) and the opcode constants ZERO..MOD = 0..7.
- One sub-module, `instr_alu`: combinational. Ports: opc, op_a, op_b -> result, div_by_zero, illegal_op. The FSM and output registers stay in `instr_exec_reader`.

## Test plan
- Run 1, `first_ptr`=3, entry 3 = {ADD, 7, -10}, `res_ready`=1 -> `result`=-3, `res_ptr`=3, `done` at N+4.
- Run 4 from `first_ptr`=30, ptrs 30,31,0,1 = {MULT, 65536, 65536}, {SUB, -2^31, 1}, {DIV, -7, 2}, {MOD, -7, 2}:
  - results 2^32, -2^31-1, -3, -1;
  - pointer wraps 31->0.
- DIV with op_b=0 -> `result`=0, `div_by_zero`=1. Without `INSTR_EXEC_DIV_EN`, the same entry gives `illegal_op`=1 and `div_by_zero`=0.
- `res_ready` low for 5 cycles in OUT -> `result`/`res_ptr` stable and no pointer advance; second `start` during the run is ignored.
- `count`=0 -> `done` pulse, no `res_valid`. `reset` asserted in EXEC of a 3-entry run -> all outputs at reset values next cycle, no `done`. Opcode 12 -> `illegal_op`=1, `result`=0.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side executor.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents:
//   operand_t / opcode_t / address_t / instruction_t : register entry layout
//   result_t  : signed 64-bit ALU result
//   ZERO..MOD : opcode encodings 0..7; encodings 8..15 are undefined
//   state_t   : read-sequencer FSM states
//   sext64    : operand sign extension to result width
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic        [3:0]  opcode_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    localparam opcode_t ZERO  = 4'd0;
    localparam opcode_t PASSA = 4'd1;
    localparam opcode_t PASSB = 4'd2;
    localparam opcode_t ADD   = 4'd3;
    localparam opcode_t SUB   = 4'd4;
    localparam opcode_t MULT  = 4'd5;
    localparam opcode_t DIV   = 4'd6;
    localparam opcode_t MOD   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_EXEC    = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    // Widening before any arithmetic keeps ADD/SUB/MULT exact in 64 bits.
    function automatic result_t sext64(input operand_t v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/instr_exec_reader_if.sv
// Bundle between the instruction-register read sequencer and its environment.
// Latency: n/a (wiring only).
// Backpressure: result bus is valid/ready; res_ready may lead res_valid.
//
// master : the sequencer (drives read_pointer and the result bus)
// slave  : the environment (drives start/first_ptr/count, instruction_word,
//          res_ready)
interface instr_exec_reader_if #(
    parameter int ADDR_W = 5
) ();
    import instr_register_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] first_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] read_pointer;
    instruction_t      instruction_word;
    logic              res_valid;
    logic              res_ready;
    result_t           result;
    logic [ADDR_W-1:0] res_ptr;
    opcode_t           res_opc;
    logic              div_by_zero;
    logic              illegal_op;
    logic              busy;
    logic              done;

    modport master (
        input  start, first_ptr, count, instruction_word, res_ready,
        output read_pointer, res_valid, result, res_ptr, res_opc,
               div_by_zero, illegal_op, busy, done
    );

    modport slave (
        output start, first_ptr, count, instruction_word, res_ready,
        input  read_pointer, res_valid, result, res_ptr, res_opc,
               div_by_zero, illegal_op, busy, done
    );

endinterface

// File: rtl/instr_alu.sv
// Combinational ALU for one instruction-register entry (signed 32b in, 64b out).
// Latency: 0 cycles (purely combinational).
// Backpressure: none; caller registers the outputs.
//
// Ports: opc, op_a, op_b -> result, div_by_zero, illegal_op
// Build option: INSTR_EXEC_DIV_EN builds the divider for DIV/MOD; without it
// DIV/MOD report illegal_op and return 0.
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opc,
    input  operand_t op_a,
    input  operand_t op_b,
    output result_t  result,
    output logic     div_by_zero,
    output logic     illegal_op
);

    result_t w_a;
    result_t w_b;

    assign w_a = sext64(op_a);
    assign w_b = sext64(op_b);

    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        illegal_op  = 1'b0;
        case (opc)
            ZERO:  result = '0;
            PASSA: result = w_a;
            PASSB: result = w_b;
            ADD:   result = w_a + w_b;
            SUB:   result = w_a - w_b;
            // 32x32 signed product always fits in 64 bits, so the
            // truncated 64-bit product is the full product.
            MULT:  result = w_a * w_b;
`ifdef INSTR_EXEC_DIV_EN
            // Dividing in 64 bits keeps -2^31 / -1 representable.
            // SV '/' truncates toward zero and '%' follows the dividend.
            DIV: begin
                if (op_b == '0) div_by_zero = 1'b1;
                else            result      = w_a / w_b;
            end
            MOD: begin
                if (op_b == '0) div_by_zero = 1'b1;
                else            result      = w_a % w_b;
            end
`else
            DIV, MOD: illegal_op = 1'b1;
`endif
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_exec_reader.sv
// Read-side sequencer: walks the instruction register, executes each entry, emits one result per entry.
// Latency: start edge N -> res_valid after N+3; 4 cycles per result with res_ready high; done in cycle N+4k.
// Backpressure: OUT holds all outputs and the read pointer stable until res_valid && res_ready.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : instr_exec_reader_if.master (start/first_ptr/count in,
//                read_pointer out, instruction_word in, result bus out,
//                busy/done status out)
// Build option: INSTR_EXEC_DIV_EN (passed through to instr_alu).
module instr_exec_reader
    import instr_register_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int ADDR_W      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    instr_exec_reader_if.master     bus
);

    localparam int CNT_W = ADDR_W + 1;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_read_pointer;
    logic [CNT_W-1:0]  r_remaining;
    instruction_t      r_instr;

    logic              r_res_valid;
    result_t           r_result;
    logic [ADDR_W-1:0] r_res_ptr;
    opcode_t           r_res_opc;
    logic              r_div_by_zero;
    logic              r_illegal_op;
    logic              r_done;

    logic              w_load_run;
    logic              w_capture;
    logic              w_exec;
    logic              w_accept;
    logic              w_more;
    logic              w_done_nxt;
    logic [ADDR_W-1:0] w_ptr_inc;

    result_t           w_alu_result;
    logic              w_alu_div_by_zero;
    logic              w_alu_illegal_op;

    // ALU reads the word latched in CAPTURE, so it is settled during EXEC.
    instr_alu u_alu (
        .opc         (r_instr.opc),
        .op_a        (r_instr.op_a),
        .op_b        (r_instr.op_b),
        .result      (w_alu_result),
        .div_by_zero (w_alu_div_by_zero),
        .illegal_op  (w_alu_illegal_op)
    );

    // Explicit wrap so a depth smaller than the pointer range still wraps.
    assign w_ptr_inc = (r_read_pointer == ADDR_W'(NUM_ENTRIES - 1))
                     ? '0 : r_read_pointer + ADDR_W'(1);

    assign w_more = (r_remaining > CNT_W'(1));

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------------------------------------------------------
    // FSM next state and datapath strobes
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_run  = 1'b0;
        w_capture   = 1'b0;
        w_exec      = 1'b0;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        w_load_run  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        // Empty run: report completion without touching the register.
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            // Settle cycle so a registered register read has caught up with read_pointer.
            S_FETCH: w_state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (r_res_valid && bus.res_ready) begin
                    w_accept = 1'b1;
                    if (w_more) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Run bookkeeping, capture register and output bus
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_pointer <= '0;
            r_remaining    <= '0;
            r_instr        <= '0;
            r_res_valid    <= 1'b0;
            r_result       <= '0;
            r_res_ptr      <= '0;
            r_res_opc      <= '0;
            r_div_by_zero  <= 1'b0;
            r_illegal_op   <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= w_done_nxt;

            if (w_load_run) begin
                r_read_pointer <= bus.first_ptr;
                r_remaining    <= bus.count;
            end

            if (w_capture) begin
                r_instr <= bus.instruction_word;
            end

            if (w_exec) begin
                r_result      <= w_alu_result;
                r_div_by_zero <= w_alu_div_by_zero;
                r_illegal_op  <= w_alu_illegal_op;
                r_res_opc     <= r_instr.opc;
                r_res_ptr     <= r_read_pointer;
                r_res_valid   <= 1'b1;
            end

            if (w_accept) begin
                r_res_valid <= 1'b0;
                r_remaining <= r_remaining - CNT_W'(1);
                // The pointer stays on the last entry when the run ends.
                if (w_more) r_read_pointer <= w_ptr_inc;
            end
        end
    end

    assign bus.read_pointer = r_read_pointer;
    assign bus.res_valid    = r_res_valid;
    assign bus.result       = r_result;
    assign bus.res_ptr      = r_res_ptr;
    assign bus.res_opc      = r_res_opc;
    assign bus.div_by_zero  = r_div_by_zero;
    assign bus.illegal_op   = r_illegal_op;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = r_done;

endmodule

// File: tb/tb_instr_exec_reader.sv
// Testbench for instr_exec_reader: directed runs plus randomized runs against a behavioural model.
// Latency: checks N+3 result latency and one result per 4 cycles from each acceptance.
// Backpressure: stalls res_ready for 5 cycles mid-run and checks outputs hold.
module tb_instr_exec_reader;
    import instr_register_pkg::*;

    logic clk;
    logic reset;

    instr_exec_reader_if #(.ADDR_W(5)) bus ();

    instr_exec_reader #(
        .NUM_ENTRIES (32),
        .ADDR_W      (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instruction_t mem [32];
    assign bus.instruction_word = mem[bus.read_pointer];

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] got_res [$];
    logic [63:0] got_ptr [$];
    logic [63:0] got_dz  [$];
    logic [63:0] got_il  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural ALU: plain 64-bit integer arithmetic on the operand values.
    function automatic void model(input opcode_t opc, input int a, input int b,
                                  output longint r, output bit dz, output bit il);
        r  = 0;
        dz = 1'b0;
        il = 1'b0;
        case (int'(opc))
            0: r = 0;
            1: r = longint'(a);
            2: r = longint'(b);
            3: r = longint'(a) + longint'(b);
            4: r = longint'(a) - longint'(b);
            5: r = longint'(a) * longint'(b);
`ifdef INSTR_EXEC_DIV_EN
            6: if (b == 0) dz = 1'b1; else r = longint'(a) / longint'(b);
            7: if (b == 0) dz = 1'b1; else r = longint'(a) % longint'(b);
`else
            6, 7: il = 1'b1;
`endif
            default: il = 1'b1;
        endcase
    endfunction

    task automatic set_entry(input int idx, input int opc, input int a, input int b);
        mem[idx].opc  = opcode_t'(opc);
        mem[idx].op_a = a;
        mem[idx].op_b = b;
    endtask

    // One complete run; stall_e is the entry whose result is held off for
    // 5 cycles (-1 for none), inject re-asserts start during that stall.
    task automatic run(input int first, input int cnt, input int stall_e, input bit inject);
        int     p;
        int     t;
        longint r;
        bit     dz;
        bit     il;
        logic [63:0] h_res;
        logic [63:0] h_ptr;
        got_res.delete(); got_ptr.delete(); got_dz.delete(); got_il.delete();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.first_ptr = 5'(first);
        bus.count     = 6'(cnt);
        @(negedge clk);
        bus.start     = 1'b0;
        check("start_ptr", bus.read_pointer, 64'(first));
        check("start_busy", bus.busy, 1);
        p = first;
        for (int e = 0; e < cnt; e++) begin
            model(mem[p].opc, mem[p].op_a, mem[p].op_b, r, dz, il);
            bus.res_ready = (e != stall_e);
            t = 0;
            while (!bus.res_valid && t < 12) begin
                @(negedge clk);
                t++;
            end
            check("latency", 64'(t), 3);
            check("result", bus.result, r);
            check("res_ptr", bus.res_ptr, 64'(p));
            check("res_opc", bus.res_opc, 64'(mem[p].opc));
            check("div_by_zero", bus.div_by_zero, 64'(dz));
            check("illegal_op", bus.illegal_op, 64'(il));
            got_res.push_back(bus.result);
            got_ptr.push_back(64'(bus.res_ptr));
            got_dz.push_back(64'(bus.div_by_zero));
            got_il.push_back(64'(bus.illegal_op));
            if (e == stall_e) begin
                h_res = bus.result;
                h_ptr = 64'(bus.res_ptr);
                for (int s = 0; s < 5; s++) begin
                    if (inject && s == 1) begin
                        bus.start     = 1'b1;
                        bus.first_ptr = 5'(17);
                        bus.count     = 6'(7);
                    end
                    @(negedge clk);
                    bus.start = 1'b0;
                    check("stall_valid", bus.res_valid, 1);
                    check("stall_result", bus.result, h_res);
                    check("stall_res_ptr", bus.res_ptr, h_ptr);
                    check("stall_rd_ptr", bus.read_pointer, 64'(p));
                end
                bus.res_ready = 1'b1;
            end
            @(negedge clk);
            check("accept_valid", bus.res_valid, 0);
            check("accept_done", bus.done, 64'(e == cnt - 1));
            check("accept_busy", bus.busy, 64'(e != cnt - 1));
            if (e != cnt - 1) check("advance_ptr", bus.read_pointer, 64'((p + 1) % 32));
            p = (p + 1) % 32;
        end
        @(negedge clk);
        check("done_pulse_end", bus.done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit any;
        int f;
        int c;
        int se;
        for (int i = 0; i < 32; i++) set_entry(i, 0, 0, 0);
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.first_ptr = '0;
        bus.count     = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rd_ptr", bus.read_pointer, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_res_ptr", bus.res_ptr, 0);
        check("rst_opc", bus.res_opc, 0);
        check("rst_dz", bus.div_by_zero, 0);
        check("rst_il", bus.illegal_op, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        reset = 1'b0;

        // Single ADD entry.
        set_entry(3, 3, 7, -10);
        run(3, 1, -1, 1'b0);
        check("add_res", got_res[0], -3);
        check("add_ptr", got_ptr[0], 3);

        // Four entries wrapping 31 -> 0.
        set_entry(30, 5, 65536, 65536);
        set_entry(31, 4, int'(32'h8000_0000), 1);
        set_entry(0, 6, -7, 2);
        set_entry(1, 7, -7, 2);
        run(30, 4, -1, 1'b0);
        check("mult_res", got_res[0], 64'h0000_0001_0000_0000);
        check("sub_res", got_res[1], -64'sd2147483649);
        check("wrap_ptr2", got_ptr[2], 0);
        check("wrap_ptr3", got_ptr[3], 1);
`ifdef INSTR_EXEC_DIV_EN
        check("div_res", got_res[2], -3);
        check("mod_res", got_res[3], -1);
`else
        check("div_res_off", got_res[2], 0);
        check("div_il_off", got_il[2], 1);
        check("mod_il_off", got_il[3], 1);
`endif

        // DIV by zero.
        set_entry(5, 6, 9, 0);
        run(5, 1, -1, 1'b0);
        check("div0_res", got_res[0], 0);
`ifdef INSTR_EXEC_DIV_EN
        check("div0_dz", got_dz[0], 1);
        check("div0_il", got_il[0], 0);
`else
        check("div0_dz_off", got_dz[0], 0);
        check("div0_il_off", got_il[0], 1);
`endif

        // Backpressure plus an ignored second start.
        set_entry(10, 1, 111, 0);
        set_entry(11, 2, 0, -222);
        run(10, 2, 0, 1'b1);
        check("stall_ptr1", got_ptr[1], 11);
        check("stall_res1", got_res[1], -222);

        // Empty run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = '0;
        @(negedge clk);
        bus.start = 1'b0;
        check("cnt0_done", bus.done, 1);
        check("cnt0_busy", bus.busy, 0);
        check("cnt0_valid", bus.res_valid, 0);
        @(negedge clk);
        check("cnt0_done_clr", bus.done, 0);
        check("cnt0_valid2", bus.res_valid, 0);

        // Reset while in EXEC of a 3-entry run.
        set_entry(7, 3, 1, 2);
        set_entry(8, 3, 3, 4);
        set_entry(9, 3, 5, 6);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.first_ptr = 5'(8);
        bus.count     = 6'(3);
        @(negedge clk);
        bus.start     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_rd_ptr", bus.read_pointer, 0);
        check("abort_valid", bus.res_valid, 0);
        check("abort_result", bus.result, 0);
        check("abort_res_ptr", bus.res_ptr, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        any = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done || bus.res_valid || bus.busy) any = 1'b1;
        end
        check("abort_quiet", any, 0);

        // Undefined opcode.
        set_entry(20, 12, 5, 6);
        run(20, 1, -1, 1'b0);
        check("illegal_flag", got_il[0], 1);
        check("illegal_res", got_res[0], 0);

        // Randomized runs.
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 32; i++) begin
                int o;
                int a;
                int b;
                o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       a = int'(32'h8000_0000);
                    1:       a = int'($urandom_range(0, 20)) - 10;
                    default: a = int'($urandom);
                endcase
                case ($urandom_range(0, 4))
                    0:       b = 0;
                    1:       b = -1;
                    2:       b = int'($urandom_range(0, 20)) - 10;
                    default: b = int'($urandom);
                endcase
                set_entry(i, o, a, b);
            end
            f  = int'($urandom_range(0, 31));
            c  = int'($urandom_range(1, 5));
            se = int'($urandom_range(0, 2)) == 0 ? int'($urandom_range(0, c - 1)) : -1;
            run(f, c, se, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
